if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage that generates PC values, issues instruction-memory reads and presents fetched words to the IF/ID register together with the matching PC+4. It drives the IF/ID register's data inputs and its write enable, so the IF/ID register loads only when a fetched instruction or a flush bubble is ready. A 2-entry fetch queue absorbs memory latency and downstream stalls. Branch and jump redirects flush the queue and drop any in-flight read.

## Interface
- RESET_PC, 32'h0000_3000, PC fetched first after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  one-cycle read request; at most one request outstanding.
- imem_addr  out  32  word address of the request; valid when imem_req=1.
- imem_rvalid  in  1  read data valid; asserted exactly once per request, at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word; sampled when imem_rvalid=1.
- stall  in  1  hazard unit holds the IF/ID register.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0.
- ins  out  32  instruction to the IF/ID register.
- pc4  out  32  PC+4 of `ins`.
- IRWr  out  1  IF/ID write enable.

## Operation
- State: pc (32), queue of 2 entries {inst, pc4}, count (0..2), FSM {ISSUE, WAIT, DISCARD}.
- Reset: pc=RESET_PC, count=0, FSM=ISSUE, imem_req=0, ins=0, pc4=0, IRWr=0.
- Outputs are combinational from the queue head:
  - redirect=1: ins=0 (nop), pc4=0, IRWr=1. The bubble is forced even when stall=1, because flush has priority.
  - Otherwise, count>0 and stall=0: ins/pc4 = head, IRWr=1, head popped.
  - Otherwise: IRWr=0, ins/pc4 = head, or 0 when empty.
- ISSUE:
  - If count<2 and redirect=0: imem_req=1, imem_addr=pc, go to WAIT.
  - Otherwise remain in ISSUE.
- WAIT, imem_rvalid=1, redirect=0:
  - Push {imem_rdata, pc+4}; pc <= pc+4.
  - If count+1−pop < 2: issue the next request at pc+4 in the same cycle and stay in WAIT.
  - Otherwise go to ISSUE.
- Redirect handling:
  - Any state: pc <= {redirect_pc[31:2],2'b00}; queue cleared (count=0); no pop and no push this cycle.
  - WAIT with imem_rvalid=0 → DISCARD.
  - WAIT with imem_rvalid=1 → data dropped, go to ISSUE.
  - ISSUE → stays in ISSUE; no request is issued that cycle.
- DISCARD:
  - imem_req=0.
  - On imem_rvalid: drop the data, go to ISSUE.
  - A redirect while in DISCARD updates pc and the state stays DISCARD.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC → 0).
- Push and pop in the same cycle with count=2 is legal; count stays 2.
- Push is never attempted when full; the issue rule guarantees room.

## Timing
- First imem_req: the first cycle with rst=0, imem_addr=RESET_PC.
- With 1-cycle memory latency (rvalid the cycle after req):
  - The word appears on ins with IRWr=1 one cycle after rvalid, i.e. 2 cycles after req.
  - Sustained throughput is 1 instruction/cycle while stall=0.
- Redirect → first request at the new PC:
  - Next cycle if the FSM was in ISSUE or had rvalid coincident.
  - Otherwise the cycle after the dropped rvalid.
- rst asserted mid-operation: all state returns to reset values at that edge; an in-flight response arriving after reset is ignored.

## Test plan
- Reset then 1-cycle memory returning addr-tagged data: imem_addr sequence 0x3000, 0x3004, 0x3008; ins/pc4 = (mem[0x3000], 0x3004), (mem[0x3004], 0x3008) on consecutive cycles, IRWr=1 each cycle.
- stall=1 for 4 cycles: queue fills to 2, imem_req stops, IRWr=0; on release, the two held instructions emerge in order with no loss or duplicate.
- redirect with redirect_pc=0x3043 while WAIT, memory latency 3: bubble ins=0/IRWr=1; late rvalid dropped; next imem_addr=0x3040; first ins afterward is mem[0x3040] with pc4=0x3044.
- redirect coincident with rvalid and stall=1: bubble emitted (IRWr=1, ins=0), queue empty, next request at the new PC the following cycle.
- pc=32'hFFFF_FFFC fetch: pc4=0x0000_0000, next imem_addr=0.
- rst pulsed mid-stream with a request outstanding: outputs zero, next imem_addr=RESET_PC, stale rvalid not enqueued.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, hazard/redirect controls
// and the IF/ID register data and write-enable.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        IRWr;

    modport master (
        output imem_req, imem_addr, ins, pc4, IRWr,
        input  imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ins, pc4, IRWr,
        output imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC generation, single-outstanding imem reads, 2-entry
// fetch queue feeding the IF/ID register; redirects flush and drop in-flight reads.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DISCARD} state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } qent_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    qent_t [1:0] q_q, q_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        pop, push, issue_new, issue_chain, widx;
    logic [1:0]  cnt_after;
    logic [31:0] pc_plus4, rpc_aligned;

    assign pc_plus4    = pc_q + 32'd4;
    assign rpc_aligned = bus.redirect_pc & ~32'd3;

    assign pop       = !bus.redirect && (cnt_q != 2'd0) && !bus.stall;
    assign push      = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    assign cnt_after = cnt_q + {1'b0, push} - {1'b0, pop};
    // Chained issue keeps the port busy every cycle while the queue drains.
    assign issue_chain = push && (cnt_after < 2'd2);
    assign issue_new   = (state_q == S_ISSUE) && (cnt_q < 2'd2) && !bus.redirect;
    // Slot for the pushed entry once the head (if popped) has shifted out.
    assign widx = ((cnt_q == 2'd2) && pop) || ((cnt_q == 2'd1) && !pop);

    assign bus.imem_req  = !rst && (issue_new || issue_chain);
    assign bus.imem_addr = issue_chain ? pc_plus4 : pc_q;
    assign bus.IRWr      = !rst && (bus.redirect || pop);
    assign bus.ins = (rst || bus.redirect || cnt_q == 2'd0) ? 32'd0 : q_q[0].inst;
    assign bus.pc4 = (rst || bus.redirect || cnt_q == 2'd0) ? 32'd0 : q_q[0].pc4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        if (bus.redirect) begin
            pc_d  = rpc_aligned;
            cnt_d = 2'd0;
            case (state_q)
                S_WAIT:    state_d = bus.imem_rvalid ? S_ISSUE : S_DISCARD;
                S_DISCARD: state_d = bus.imem_rvalid ? S_ISSUE : S_DISCARD;
                default:   state_d = S_ISSUE;
            endcase
        end else begin
            if (pop) q_d[0] = q_q[1];
            if (push) begin
                q_d[widx] = '{inst: bus.imem_rdata, pc4: pc_plus4};
                pc_d      = pc_plus4;
            end
            cnt_d = cnt_after;
            case (state_q)
                S_ISSUE:   if (issue_new) state_d = S_WAIT;
                S_WAIT:    if (bus.imem_rvalid) state_d = issue_chain ? S_WAIT : S_ISSUE;
                S_DISCARD: if (bus.imem_rvalid) state_d = S_ISSUE;
                default:   state_d = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ISSUE;
            pc_q    <= RESET_PC;
            q_q     <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a fixed-latency, address-tagged
// instruction memory responder.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat   = 1;

    logic        pend_v   = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_a   = 32'd0;

    if_fetch_unit_if bus();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic out_is(input string tag, input logic irwr, input logic [31:0] ins,
                          input logic [31:0] pc4);
        chk({tag, ".IRWr"}, {31'd0, bus.IRWr}, {31'd0, irwr});
        chk({tag, ".ins"}, bus.ins, ins);
        chk({tag, ".pc4"}, bus.pc4, pc4);
    endtask

    task automatic req_is(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, bus.imem_addr, addr);
    endtask

    // One cycle: apply inputs and any due memory response at the falling edge,
    // then let combinational outputs settle before the caller samples them.
    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        rst             = r;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        if (pend_v) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memf(pend_a);
                pend_v          = 1'b0;
            end
        end
        #1;
        if (bus.imem_req) begin
            chk("one_outstanding", {31'd0, pend_v}, 32'd0);
            pend_v   = 1'b1;
            pend_cnt = lat;
            pend_a   = bus.imem_addr;
        end
    endtask

    task automatic do_reset();
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;

        // Reset state, then streaming with 1-cycle memory
        lat = 1;
        do_reset();
        out_is("rst", 1'b0, 32'd0, 32'd0);
        req_is("rst", 1'b0, 32'd0);
        step(0, 0, 0, 0); req_is("t1a", 1, 32'h3000); out_is("t1a", 0, 0, 0);
        step(0, 0, 0, 0); req_is("t1b", 1, 32'h3004); out_is("t1b", 0, 0, 0);
        step(0, 0, 0, 0); req_is("t1c", 1, 32'h3008); out_is("t1c", 1, memf(32'h3000), 32'h3004);
        step(0, 0, 0, 0); req_is("t1d", 1, 32'h300C); out_is("t1d", 1, memf(32'h3004), 32'h3008);

        // Stall for 4 cycles: queue fills, requests stop, head held
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            req_is("t2stall", 0, 0);
            out_is("t2stall", 0, memf(32'h3008), 32'h300C);
        end
        step(0, 0, 0, 0); req_is("t2i", 0, 0);            out_is("t2i", 1, memf(32'h3008), 32'h300C);
        step(0, 0, 0, 0); req_is("t2j", 1, 32'h3010);     out_is("t2j", 1, memf(32'h300C), 32'h3010);
        step(0, 0, 0, 0); req_is("t2k", 1, 32'h3014);     out_is("t2k", 0, 0, 0);
        step(0, 0, 0, 0);                                 out_is("t2l", 1, memf(32'h3010), 32'h3014);

        // Redirect while waiting on a 3-cycle memory
        lat = 3;
        do_reset();
        step(0, 0, 0, 0);            req_is("t3a", 1, 32'h3000);
        step(0, 0, 1, 32'h0000_3043); req_is("t3b", 0, 0); out_is("t3b", 1, 0, 0);
        step(0, 0, 0, 0);            req_is("t3c", 0, 0); out_is("t3c", 0, 0, 0);
        step(0, 0, 0, 0);            req_is("t3d", 0, 0); out_is("t3d", 0, 0, 0);
        step(0, 0, 0, 0);            req_is("t3e", 1, 32'h3040);
        step(0, 0, 0, 0);            req_is("t3f", 0, 0);
        step(0, 0, 0, 0);            req_is("t3g", 0, 0);
        step(0, 0, 0, 0);            req_is("t3h", 1, 32'h3044); out_is("t3h", 0, 0, 0);
        step(0, 0, 0, 0);            out_is("t3i", 1, memf(32'h3040), 32'h3044);

        // Redirect coincident with rvalid while stalled
        lat = 1;
        do_reset();
        step(0, 0, 0, 0);             req_is("t4a", 1, 32'h3000);
        step(0, 0, 0, 0);             req_is("t4b", 1, 32'h3004);
        step(0, 1, 1, 32'h0000_5000); req_is("t4c", 0, 0); out_is("t4c", 1, 0, 0);
        step(0, 0, 0, 0);             req_is("t4d", 1, 32'h5000); out_is("t4d", 0, 0, 0);
        step(0, 0, 0, 0);             req_is("t4e", 1, 32'h5004); out_is("t4e", 0, 0, 0);
        step(0, 0, 0, 0);             out_is("t4f", 1, memf(32'h5000), 32'h5004);

        // PC wrap at the top of the address space
        do_reset();
        step(0, 0, 1, 32'hFFFF_FFFC); req_is("t5a", 0, 0); out_is("t5a", 1, 0, 0);
        step(0, 0, 0, 0);             req_is("t5b", 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);             req_is("t5c", 1, 32'h0000_0000);
        step(0, 0, 0, 0);             req_is("t5d", 1, 32'h0000_0004);
        out_is("t5d", 1, memf(32'hFFFF_FFFC), 32'h0000_0000);
        step(0, 0, 0, 0);             out_is("t5e", 1, memf(32'h0000_0000), 32'h0000_0004);

        // Reset pulsed with a request outstanding; stale response lands in reset
        lat = 3;
        do_reset();
        step(0, 0, 0, 0); req_is("t6a", 1, 32'h3000);
        step(1, 0, 0, 0); req_is("t6b", 0, 0); out_is("t6b", 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0); out_is("t6c", 0, 0, 0);
        step(0, 0, 0, 0); req_is("t6d", 1, 32'h3000); out_is("t6d", 0, 0, 0);
        step(0, 0, 0, 0); out_is("t6e", 0, 0, 0);
        step(0, 0, 0, 0); out_is("t6f", 0, 0, 0);
        step(0, 0, 0, 0); req_is("t6g", 1, 32'h3004); out_is("t6g", 0, 0, 0);
        step(0, 0, 0, 0); out_is("t6h", 1, memf(32'h3000), 32'h3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
